// File: rtl/wf_capture_buf_if.sv
// Bus bundle for wf_capture_buf: CIC sample input, capture control,
// host read port and status. The master side is the CIC/host, the slave
// side is the capture buffer.
interface wf_capture_buf_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 10
);
    logic                         in_strobe;
    logic signed [DATA_WIDTH-1:0] in_i;
    logic signed [DATA_WIDTH-1:0] in_q;
    logic                         start;
    logic                         abort;
    logic [DEPTH_LOG2:0]          length;
    logic                         rd_en;
    logic [DEPTH_LOG2-1:0]        rd_addr;
    logic [2*DATA_WIDTH-1:0]      rd_data;
    logic                         rd_valid;
    logic [DEPTH_LOG2:0]          wr_count;
    logic                         busy;
    logic                         done;

    modport master (
        output in_strobe, in_i, in_q, start, abort, length, rd_en, rd_addr,
        input  rd_data, rd_valid, wr_count, busy, done
    );

    modport slave (
        input  in_strobe, in_i, in_q, start, abort, length, rd_en, rd_addr,
        output rd_data, rd_valid, wr_count, busy, done
    );
endinterface

// File: rtl/wf_capture_buf.sv
// Waterfall capture buffer: drops the CIC settling transient (FLUSH strobes)
// after a start, then stores a programmed number of decimated {I,Q} pairs in
// a simple-dual-port RAM that the host reads through a registered port.
module wf_capture_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int FLUSH      = 5
) (
    input  logic           clock,
    input  logic           reset,
    wf_capture_buf_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FCW   = $clog2(FLUSH + 2);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FLUSH   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Full-depth length in the length/count width (a 1 followed by zeros).
    localparam logic [DEPTH_LOG2:0] DEPTH_V    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [FCW-1:0]      FLUSH_LAST = FCW'((FLUSH > 0) ? (FLUSH - 1) : 0);
    localparam logic [FCW-1:0]      FCNT_ONE   = FCW'(1);

    logic [1:0]              r_state;
    logic [FCW-1:0]          r_flush_cnt;
    logic [DEPTH_LOG2:0]     r_len_q;
    logic [DEPTH_LOG2:0]     r_wr_count;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_rd_valid;
    logic [2*DATA_WIDTH-1:0] r_rd_data;
    logic [2*DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic [1:0]          w_state_nxt;
    logic [DEPTH_LOG2:0] w_len_eff;
    logic                w_flush_last;
    logic                w_cap_last;
    logic                w_wr_en;

    assign w_flush_last = (r_flush_cnt == FLUSH_LAST);
    assign w_cap_last   = ((r_wr_count + CNT_ONE) == r_len_q);
    // abort outranks a coincident strobe: nothing is written on an abort cycle.
    assign w_wr_en      = (r_state == S_CAPTURE) && bus.in_strobe && !bus.abort;

    // Length to latch on start: 0 and anything above the depth map to full depth.
    always_comb begin
        w_len_eff = bus.length;
        if ((bus.length == {(DEPTH_LOG2+1){1'b0}}) || (bus.length > DEPTH_V)) begin
            w_len_eff = DEPTH_V;
        end else begin
            w_len_eff = bus.length;
        end
    end

    // Next-state decode; abort wins over everything including a same-cycle start.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        w_state_nxt = (FLUSH == 0) ? S_CAPTURE : S_FLUSH;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_FLUSH: begin
                    if (bus.in_strobe && w_flush_last) begin
                        w_state_nxt = S_CAPTURE;
                    end else begin
                        w_state_nxt = S_FLUSH;
                    end
                end
                S_CAPTURE: begin
                    if (bus.in_strobe && w_cap_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_CAPTURE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Control state, counters and status; wr_count survives abort so partial data stays readable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= {FCW{1'b0}};
            r_len_q     <= {(DEPTH_LOG2+1){1'b0}};
            r_wr_count  <= {(DEPTH_LOG2+1){1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_FLUSH) || (w_state_nxt == S_CAPTURE);
            if (bus.abort) begin
                r_done <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (bus.start) begin
                            r_wr_count  <= {(DEPTH_LOG2+1){1'b0}};
                            r_done      <= 1'b0;
                            r_flush_cnt <= {FCW{1'b0}};
                            r_len_q     <= w_len_eff;
                        end
                    end
                    S_FLUSH: begin
                        if (bus.in_strobe) begin
                            r_flush_cnt <= r_flush_cnt + FCNT_ONE;
                        end
                    end
                    S_CAPTURE: begin
                        if (bus.in_strobe) begin
                            r_wr_count <= r_wr_count + CNT_ONE;
                            if (w_cap_last) begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_done <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sample RAM write port; the array has no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_count[DEPTH_LOG2-1:0]] <= {bus.in_i, bus.in_q};
        end
    end

    // Registered host read port: old data on a same-address write, holds when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= {(2*DATA_WIDTH){1'b0}};
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= r_mem[bus.rd_addr];
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.wr_count = r_wr_count;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_wf_capture_buf.sv
// Directed self-checking bench for wf_capture_buf (DEPTH_LOG2=4, FLUSH=5).
module tb_wf_capture_buf;
    localparam int DW  = 16;
    localparam int DL2 = 4;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    wf_capture_buf_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) bus ();

    wf_capture_buf #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .FLUSH(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic pulse_start(input logic [DL2:0] len);
        bus.start  = 1'b1;
        bus.length = len;
        cyc();
        bus.start  = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
    endtask

    task automatic strobe(input logic [DW-1:0] i, input logic [DW-1:0] q, input int gap);
        bus.in_strobe = 1'b1;
        bus.in_i      = i;
        bus.in_q      = q;
        cyc();
        bus.in_strobe = 1'b0;
        repeat (gap) cyc();
    endtask

    task automatic read(input logic [DL2-1:0] a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        cyc();
        bus.rd_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) cyc();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        checks++; if (bus.wr_count !== 5'd0) begin failures++; $display("FAIL reset_wr_count got=%0d exp=0", bus.wr_count); end
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        logic [DW-1:0] ei;
        logic [DW-1:0] eq;
        pulse_start(5'd4);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%0b exp=1", bus.busy); end
        for (int k = 1; k <= 12; k++) begin
            strobe(16'(k), 16'(-k), 2);
            if (k == 8) begin
                checks++; if (bus.done !== 1'b0 || bus.wr_count !== 5'd3) begin failures++; $display("FAIL basic_before_last done=%0b wr=%0d exp done=0 wr=3", bus.done, bus.wr_count); end
            end
            if (k == 9) begin
                checks++; if (bus.done !== 1'b1 || bus.wr_count !== 5'd4 || bus.busy !== 1'b0) begin failures++; $display("FAIL basic_done done=%0b wr=%0d busy=%0b exp 1/4/0", bus.done, bus.wr_count, bus.busy); end
            end
        end
        checks++; if (bus.wr_count !== 5'd4 || bus.done !== 1'b1) begin failures++; $display("FAIL basic_extra_ignored wr=%0d done=%0b exp 4/1", bus.wr_count, bus.done); end
        for (int a = 0; a < 4; a++) begin
            ei = 16'(a + 6);
            eq = 16'(-(a + 6));
            read(4'(a));
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== {ei, eq}) begin failures++; $display("FAIL basic_mem[%0d] got=%h v=%0b exp=%h", a, bus.rd_data, bus.rd_valid, {ei, eq}); end
        end
        cyc();
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL basic_rd_valid_drop got=%0b exp=0", bus.rd_valid); end
    endtask

    task automatic test_len0();
        pulse_start(5'd0);
        for (int k = 0; k < 5; k++) strobe(16'h00F0, 16'h00F0, 0);
        for (int k = 0; k < 16; k++) strobe(16'(16'h0100 + k), 16'(k), 0);
        checks++; if (bus.wr_count !== 5'd16 || bus.done !== 1'b1) begin failures++; $display("FAIL len0_full wr=%0d done=%0b exp 16/1", bus.wr_count, bus.done); end
        strobe(16'hDEAD, 16'hBEEF, 0);
        read(4'd0);
        checks++; if (bus.rd_data !== 32'h0100_0000) begin failures++; $display("FAIL len0_mem0 got=%h exp=01000000", bus.rd_data); end
        read(4'd15);
        checks++; if (bus.rd_data !== 32'h010F_000F) begin failures++; $display("FAIL len0_mem15 got=%h exp=010f000f", bus.rd_data); end
        checks++; if (bus.wr_count !== 5'd16) begin failures++; $display("FAIL len0_17th wr=%0d exp=16", bus.wr_count); end
    endtask

    task automatic test_clamp();
        pulse_start(5'd17);
        for (int k = 0; k < 5; k++) strobe(16'h00F1, 16'h00F1, 0);
        for (int k = 0; k < 15; k++) strobe(16'(16'h0200 + k), 16'(k), 0);
        checks++; if (bus.done !== 1'b0 || bus.wr_count !== 5'd15) begin failures++; $display("FAIL clamp_15 done=%0b wr=%0d exp 0/15", bus.done, bus.wr_count); end
        strobe(16'h020F, 16'h000F, 0);
        checks++; if (bus.done !== 1'b1 || bus.wr_count !== 5'd16) begin failures++; $display("FAIL clamp_16 done=%0b wr=%0d exp 1/16", bus.done, bus.wr_count); end
    endtask

    task automatic test_restart_ignored();
        pulse_start(5'd3);
        for (int k = 0; k < 5; k++) strobe(16'h00F2, 16'h00F2, 1);
        strobe(16'h0300, 16'h0300, 1);
        strobe(16'h0301, 16'h0301, 1);
        pulse_start(5'd8);
        checks++; if (bus.busy !== 1'b1 || bus.wr_count !== 5'd2 || bus.done !== 1'b0) begin failures++; $display("FAIL restart_ignored busy=%0b wr=%0d done=%0b exp 1/2/0", bus.busy, bus.wr_count, bus.done); end
        strobe(16'h0302, 16'h0302, 1);
        checks++; if (bus.done !== 1'b1 || bus.wr_count !== 5'd3) begin failures++; $display("FAIL restart_orig_len done=%0b wr=%0d exp 1/3", bus.done, bus.wr_count); end
    endtask

    task automatic test_abort();
        pulse_start(5'd8);
        for (int k = 0; k < 5; k++) strobe(16'h00F3, 16'h00F3, 0);
        strobe(16'h00A1, 16'h00B1, 0);
        strobe(16'h00A2, 16'h00B2, 0);
        pulse_abort();
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_count !== 5'd2) begin failures++; $display("FAIL abort_state busy=%0b done=%0b wr=%0d exp 0/0/2", bus.busy, bus.done, bus.wr_count); end
        read(4'd1);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h00A2_00B2) begin failures++; $display("FAIL abort_read v=%0b got=%h exp=00a200b2", bus.rd_valid, bus.rd_data); end
        cyc();
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h00A2_00B2) begin failures++; $display("FAIL abort_read_hold v=%0b got=%h exp=00a200b2", bus.rd_valid, bus.rd_data); end
        bus.start  = 1'b1;
        bus.abort  = 1'b1;
        bus.length = 5'd4;
        cyc();
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_start_same busy=%0b exp=0", bus.busy); end
        for (int k = 0; k < 6; k++) strobe(16'h00F4, 16'h00F4, 0);
        checks++; if (bus.busy !== 1'b0 || bus.wr_count !== 5'd2) begin failures++; $display("FAIL abort_idle_strobes busy=%0b wr=%0d exp 0/2", bus.busy, bus.wr_count); end
    endtask

    task automatic test_rbw();
        pulse_start(5'd4);
        for (int k = 0; k < 5; k++) strobe(16'h00F5, 16'h00F5, 0);
        bus.in_strobe = 1'b1;
        bus.in_i      = 16'h00C1;
        bus.in_q      = 16'h00C2;
        bus.rd_en     = 1'b1;
        bus.rd_addr   = 4'd0;
        cyc();
        bus.in_strobe = 1'b0;
        bus.rd_en     = 1'b0;
        checks++; if (bus.rd_data !== 32'h00A1_00B1) begin failures++; $display("FAIL rbw_old got=%h exp=00a100b1", bus.rd_data); end
        read(4'd0);
        checks++; if (bus.rd_data !== 32'h00C1_00C2) begin failures++; $display("FAIL rbw_new got=%h exp=00c100c2", bus.rd_data); end
    endtask

    task automatic test_async_reset();
        pulse_abort();
        pulse_start(5'd4);
        for (int k = 0; k < 3; k++) strobe(16'h00F6, 16'h00F6, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.rd_data !== 32'h0 || bus.wr_count !== 5'd0 || bus.done !== 1'b0) begin failures++; $display("FAIL async_reset busy=%0b rd=%h wr=%0d done=%0b exp 0/0/0/0", bus.busy, bus.rd_data, bus.wr_count, bus.done); end
        cyc();
        reset = 1'b0;
        cyc();
        pulse_start(5'd2);
        for (int k = 1; k <= 5; k++) strobe(16'(16'h0400 + k), 16'(16'h0500 + k), 0);
        checks++; if (bus.busy !== 1'b1 || bus.wr_count !== 5'd0 || bus.done !== 1'b0) begin failures++; $display("FAIL async_flush_restart busy=%0b wr=%0d done=%0b exp 1/0/0", bus.busy, bus.wr_count, bus.done); end
        strobe(16'h0406, 16'h0506, 0);
        strobe(16'h0407, 16'h0507, 0);
        checks++; if (bus.done !== 1'b1 || bus.wr_count !== 5'd2) begin failures++; $display("FAIL async_capture done=%0b wr=%0d exp 1/2", bus.done, bus.wr_count); end
        read(4'd0);
        checks++; if (bus.rd_data !== 32'h0406_0506) begin failures++; $display("FAIL async_mem0 got=%h exp=04060506", bus.rd_data); end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.in_strobe = 1'b0;
        bus.in_i      = 16'h0;
        bus.in_q      = 16'h0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.length    = 5'd0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = 4'd0;
        cyc();
        test_reset();
        test_basic();
        test_len0();
        test_clamp();
        test_restart_ignored();
        test_abort();
        test_rbw();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wf_capture_buf.md
Name: wf_capture_buf

Overview:
- Sits directly downstream of the waterfall variable-decimation CIC.
- Consumes the CIC's out_strobe / out_data for the I and Q channels.
- Discards the CIC settling transient, then captures a programmed number of decimated I/Q pairs into an internal buffer.
- Exposes a registered random-access read port for the host bus bridge, with busy/done status for software polling.

Parameters:
- DATA_WIDTH, 16, width of each I and Q sample; equals the CIC OUT_WIDTH.
- DEPTH_LOG2, 10, buffer depth is 2**DEPTH_LOG2 I/Q pairs.
- FLUSH, 5, number of in_strobe samples discarded after start; equals CIC STAGES. 0 is legal.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_strobe  in  1  one-cycle valid for in_i/in_q; driven by the CIC out_strobe.
- in_i  in  DATA_WIDTH  signed I sample.
- in_q  in  DATA_WIDTH  signed Q sample.
- start  in  1  one-cycle pulse that arms a capture.
- abort  in  1  one-cycle pulse that cancels a capture.
- length  in  DEPTH_LOG2+1  number of pairs to capture; sampled on an accepted start.
- rd_en  in  1  read request.
- rd_addr  in  DEPTH_LOG2  read address.
- rd_data  out  2*DATA_WIDTH  {I,Q} at rd_addr; I is in the upper half.
- rd_valid  out  1  high the cycle after rd_en.
- wr_count  out  DEPTH_LOG2+1  pairs written in the current or last capture.
- busy  out  1  high in FLUSH or CAPTURE.
- done  out  1  capture completed; sticky.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - State goes to IDLE.
  - wr_count=0, busy=0, done=0, rd_valid=0, rd_data=0.
  - Buffer contents are not reset.
- States: IDLE, FLUSH, CAPTURE, DONE. busy = (FLUSH or CAPTURE), registered.
- Latched length (len_q): captured on an accepted start.
  - length==0 means 2**DEPTH_LOG2.
  - length > 2**DEPTH_LOG2 is clamped to 2**DEPTH_LOG2.
- IDLE/DONE + start:
  - Next state is FLUSH, or CAPTURE directly if FLUSH==0.
  - wr_count<=0, done<=0, flush counter<=0, len_q latched.
- start while busy is ignored. It does not restart and does not relatch length.
- FLUSH:
  - Each in_strobe increments the flush counter and is not stored.
  - On the FLUSH-th strobe, go to CAPTURE. That strobe is still discarded.
- CAPTURE, on each in_strobe:
  - mem[wr_count[DEPTH_LOG2-1:0]] <= {in_i,in_q}; wr_count <= wr_count+1.
  - When wr_count+1 == len_q: go to DONE and set done on that same edge.
- DONE holds done=1 and wr_count; it waits for start.
- abort from any state:
  - Next state IDLE, done<=0. wr_count is held, so partial data stays readable.
  - abort and start in the same cycle: abort wins, the start is dropped.
- start and in_strobe in the same cycle in IDLE: that strobe is not counted; the FSM acts from the next cycle.
- Samples with in_strobe=0 are ignored in every state. in_strobe outside FLUSH/CAPTURE is ignored.
- Read port:
  - rd_data <= mem[rd_addr] when rd_en; rd_valid <= rd_en.
  - One-cycle latency, available in every state.
  - Read and write to the same address in the same cycle returns the old data (read-before-write).
  - rd_data holds its value when rd_en=0.
- Memory is a single inferred simple-dual-port RAM: one write port, one registered read port, no output reset on the array.
- Reset asserted mid-capture aborts immediately (async). The first start after deassert begins a fresh capture.

Test Plan:
- Reset, then start with length=4, FLUSH=5, strobes every 3 cycles with I=1..12, Q=-I:
  - busy rises the cycle after start.
  - I=1..5 are discarded.
  - mem[0..3] = {6,-6}..{9,-9}.
  - done=1 on the edge of the 9th strobe; wr_count=4.
  - Strobes 10..12 are ignored.
- length=0 with DEPTH_LOG2=4:
  - 16 pairs are captured; wr_count=16 and done=1.
  - A 17th strobe does not overwrite mem[0].
- Start pulsed again at wr_count=2 during CAPTURE:
  - Ignored; capture completes at the original length.
- Abort asserted after 2 captured pairs:
  - State is IDLE, busy=0, done=0, wr_count=2.
  - rd_addr=1 returns the second pair with rd_valid one cycle after rd_en.
  - start and abort in the same cycle leave the block in IDLE.
- During CAPTURE, rd_en with rd_addr equal to the address being written on the same cycle:
  - Returns the previous contents.
  - The next read of that address returns the new pair.
- Reset asserted asynchronously mid-FLUSH, between clock edges:
  - Outputs are cleared immediately.
  - The next start restarts the flush count from 0.
